// File: rtl/io_select_if.sv
// Bus-side bundle for the I/O select decoder: qualified request in,
// one-hot chip-select and wait request out.
interface io_select_if #(
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 4
);
  logic [ADDR_W-1:0]     addr_in;
  logic                  req;
  logic                  enable;
  logic [2**SEL_W-1:0]   decoder_out;
  logic                  wait_out;
  logic                  hit;
  logic                  busy;

  modport master (
    output addr_in, req, enable,
    input  decoder_out, wait_out, hit, busy
  );

  modport slave (
    input  addr_in, req, enable,
    output decoder_out, wait_out, hit, busy
  );
endinterface

// File: rtl/io_select_decoder.sv
// Registered I/O port decoder: base match, one-hot select held for the
// whole request, programmable wait-states and post-access recovery.
module io_select_decoder #(
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 4,
  parameter logic [ADDR_W-SEL_W-1:0] BASE = 'h2,
  parameter int WAIT_CYCLES     = 2,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  io_select_if.slave  bus
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic [3:0] W_LOAD =
    4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [3:0] R_LOAD =
    4'((RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACTIVE,
    MISS,
    RECOVER
  } state_t;

  localparam state_t END_ST =
    (RECOVERY_CYCLES > 0) ? RECOVER : IDLE;

  state_t             state, state_d;
  logic [3:0]         cnt, cnt_d;
  logic [SEL_W-1:0]   sel, sel_d;
  logic               armed, armed_d;
  logic [OUT_W-1:0]   dec_d;
  logic               wait_d;
  logic               hit_d;
  logic               busy_d;
  logic               match;

  assign match = (bus.addr_in[ADDR_W-1:SEL_W] == BASE);

  // armed: req has been seen low since the last access was taken,
  // so a level held across an access never retriggers a decode
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sel_d   = sel;
    armed_d = armed | ~bus.req;
    unique case (state)
      IDLE: begin
        if (bus.req && armed) begin
          armed_d = 1'b0;
          if (bus.enable && match) begin
            sel_d = bus.addr_in[SEL_W-1:0];
            if (WAIT_CYCLES > 0) begin
              state_d = WAIT;
              cnt_d   = W_LOAD;
            end else begin
              state_d = ACTIVE;
            end
          end else begin
            state_d = MISS;
          end
        end
      end
      WAIT, ACTIVE: begin
        if (!bus.req) begin
          state_d = END_ST;
          cnt_d   = R_LOAD;
        end else if (!bus.enable) begin
          state_d = MISS;
        end else if (state == WAIT) begin
          if (cnt == '0) state_d = ACTIVE;
          else           cnt_d   = cnt - 4'd1;
        end
      end
      MISS: begin
        if (!bus.req) begin
          state_d = END_ST;
          cnt_d   = R_LOAD;
        end
      end
      RECOVER: begin
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    hit_d  = (state_d == WAIT) || (state_d == ACTIVE);
    wait_d = (state_d == WAIT);
    busy_d = (state_d != IDLE);
    dec_d  = hit_d ? (OUT_W'(1) << sel_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      sel             <= '0;
      armed           <= 1'b1;
      bus.decoder_out <= '0;
      bus.wait_out    <= 1'b0;
      bus.hit         <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      sel             <= sel_d;
      armed           <= armed_d;
      bus.decoder_out <= dec_d;
      bus.wait_out    <= wait_d;
      bus.hit         <= hit_d;
      bus.busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_io_select_decoder.sv
// Bench for io_select_decoder: directed scenarios plus randomized traffic
// on two configurations checked against an access-level model.
module tb_io_select_decoder;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  io_select_if #(.ADDR_W(8), .SEL_W(4)) a_if ();
  io_select_if #(.ADDR_W(8), .SEL_W(4)) b_if ();

  io_select_decoder #(
    .ADDR_W(8), .SEL_W(4), .BASE(4'h2),
    .WAIT_CYCLES(2), .RECOVERY_CYCLES(1)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave)
  );

  io_select_decoder #(
    .ADDR_W(8), .SEL_W(4), .BASE(4'h2),
    .WAIT_CYCLES(0), .RECOVERY_CYCLES(0)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Access-level model: who owns the bus, wait-states left,
  // recovery cycles left, and whether req was seen low since.
  int m_sel  [2];
  int m_wait [2];
  int m_cool [2];
  bit m_miss [2];
  bit m_low  [2];
  int mw [2] = '{2, 0};
  int mr [2] = '{1, 0};

  task automatic model_step(input int d, input logic r,
                            input logic e, input logic [7:0] a);
    if (m_sel[d] >= 0) begin
      if (!r || !e) begin
        m_sel[d] = -1;
        if (r) m_miss[d] = 1'b1;
        else   m_cool[d] = mr[d];
      end else if (m_wait[d] > 0) begin
        m_wait[d]--;
      end
    end else if (m_miss[d]) begin
      if (!r) begin
        m_miss[d] = 1'b0;
        m_cool[d] = mr[d];
      end
    end else if (m_cool[d] > 0) begin
      m_cool[d]--;
    end else if (r && m_low[d]) begin
      m_low[d] = 1'b0;
      if (e && a[7:4] == 4'h2) begin
        m_sel[d]  = int'(a[3:0]);
        m_wait[d] = mw[d];
      end else begin
        m_miss[d] = 1'b1;
      end
    end
    if (!r) m_low[d] = 1'b1;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        m_sel[d] = -1; m_wait[d] = 0; m_cool[d] = 0;
        m_miss[d] = 1'b0; m_low[d] = 1'b1;
      end
    end else begin
      model_step(0, a_if.req, a_if.enable, a_if.addr_in);
      model_step(1, b_if.req, b_if.enable, b_if.addr_in);
    end
  end

  function automatic logic [15:0] exp_dec(int d);
    return (m_sel[d] >= 0) ? (16'(1) << m_sel[d]) : 16'h0;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_if.req = 1'b0; a_if.enable = 1'b1; a_if.addr_in = 8'h00;
    b_if.req = 1'b0; b_if.enable = 1'b1; b_if.addr_in = 8'h00;
    tick(); tick();
    reset = 1'b0;
    tick();
    total++;
    if (a_if.decoder_out !== 16'h0 || a_if.wait_out !== 1'b0)
      $display("FAIL reset_a_out got dec=%h wait=%b want 0000/0",
               a_if.decoder_out, a_if.wait_out);
    else passed++;
    total++;
    if (a_if.hit !== 1'b0 || a_if.busy !== 1'b0)
      $display("FAIL reset_a_flags got hit=%b busy=%b want 0/0",
               a_if.hit, a_if.busy);
    else passed++;
    total++;
    if (b_if.decoder_out !== 16'h0 || b_if.busy !== 1'b0)
      $display("FAIL reset_b got dec=%h busy=%b want 0000/0",
               b_if.decoder_out, b_if.busy);
    else passed++;
  endtask

  task automatic test_basic();
    a_if.addr_in = 8'h25; a_if.req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (a_if.decoder_out !== 16'h0020 || a_if.hit !== 1'b1)
        $display("FAIL basic_dec cyc%0d got %h hit=%b want 0020 hit=1",
                 i, a_if.decoder_out, a_if.hit);
      else passed++;
      total++;
      if (a_if.wait_out !== (i < 2))
        $display("FAIL basic_wait cyc%0d got %b want %b",
                 i, a_if.wait_out, (i < 2));
      else passed++;
    end
    a_if.req = 1'b0;
    tick();
    total++;
    if (a_if.decoder_out !== 16'h0 || a_if.busy !== 1'b1)
      $display("FAIL basic_release got dec=%h busy=%b want 0000/1",
               a_if.decoder_out, a_if.busy);
    else passed++;
    tick();
    total++;
    if (a_if.busy !== 1'b0)
      $display("FAIL basic_recover got busy=%b want 0", a_if.busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    a_if.addr_in = 8'h25; a_if.req = 1'b1;
    tick();
    reset = 1'b1; a_if.req = 1'b0;
    tick();
    total++;
    if (a_if.decoder_out !== 16'h0 || a_if.wait_out !== 1'b0 ||
        a_if.busy !== 1'b0)
      $display("FAIL reset_mid got dec=%h wait=%b busy=%b want 0000/0/0",
               a_if.decoder_out, a_if.wait_out, a_if.busy);
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_miss();
    a_if.addr_in = 8'h35; a_if.req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (a_if.decoder_out !== 16'h0 || a_if.wait_out !== 1'b0 ||
          a_if.hit !== 1'b0 || a_if.busy !== 1'b1)
        $display("FAIL miss cyc%0d got dec=%h w=%b h=%b b=%b want 0/0/0/1",
                 i, a_if.decoder_out, a_if.wait_out, a_if.hit, a_if.busy);
      else passed++;
    end
    a_if.req = 1'b0;
    tick();
    total++;
    if (a_if.busy !== 1'b1)
      $display("FAIL miss_recover got busy=%b want 1", a_if.busy);
    else passed++;
    tick();
    total++;
    if (a_if.busy !== 1'b0)
      $display("FAIL miss_idle got busy=%b want 0", a_if.busy);
    else passed++;
  endtask

  task automatic test_addr_walk();
    logic [15:0] want;
    for (int n = 0; n < 16; n++) begin
      want = 16'(1) << n;
      a_if.addr_in = {4'h2, 4'(n)}; a_if.req = 1'b1;
      tick();
      total++;
      if (a_if.decoder_out !== want || !$onehot(a_if.decoder_out))
        $display("FAIL walk_dec n=%0d got %h want %h",
                 n, a_if.decoder_out, want);
      else passed++;
      a_if.addr_in = 8'($urandom);
      tick(); tick();
      total++;
      if (a_if.decoder_out !== want || a_if.hit !== 1'b1)
        $display("FAIL walk_hold n=%0d got %h want %h",
                 n, a_if.decoder_out, want);
      else passed++;
      a_if.req = 1'b0;
      tick(); tick();
    end
  endtask

  task automatic test_enable_drop();
    a_if.addr_in = 8'h2A; a_if.req = 1'b1; a_if.enable = 1'b1;
    tick(); tick(); tick();
    total++;
    if (a_if.decoder_out !== 16'h0400 || a_if.wait_out !== 1'b0)
      $display("FAIL en_active got dec=%h wait=%b want 0400/0",
               a_if.decoder_out, a_if.wait_out);
    else passed++;
    a_if.enable = 1'b0;
    tick();
    total++;
    if (a_if.decoder_out !== 16'h0 || a_if.hit !== 1'b0 ||
        a_if.busy !== 1'b1)
      $display("FAIL en_drop got dec=%h hit=%b busy=%b want 0000/0/1",
               a_if.decoder_out, a_if.hit, a_if.busy);
    else passed++;
    a_if.enable = 1'b1;
    tick(); tick();
    total++;
    if (a_if.decoder_out !== 16'h0 || a_if.busy !== 1'b1)
      $display("FAIL en_noretrig got dec=%h busy=%b want 0000/1",
               a_if.decoder_out, a_if.busy);
    else passed++;
    a_if.req = 1'b0;
    tick(); tick();
    total++;
    if (a_if.busy !== 1'b0)
      $display("FAIL en_idle got busy=%b want 0", a_if.busy);
    else passed++;
    a_if.req = 1'b1;
    tick();
    total++;
    if (a_if.decoder_out !== 16'h0400)
      $display("FAIL en_new got dec=%h want 0400", a_if.decoder_out);
    else passed++;
    a_if.req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    b_if.addr_in = 8'h21; b_if.req = 1'b1; b_if.enable = 1'b1;
    tick();
    total++;
    if (b_if.decoder_out !== 16'h0002 || b_if.wait_out !== 1'b0)
      $display("FAIL b2b_first got dec=%h wait=%b want 0002/0",
               b_if.decoder_out, b_if.wait_out);
    else passed++;
    b_if.req = 1'b0;
    tick();
    total++;
    if (b_if.decoder_out !== 16'h0 || b_if.busy !== 1'b0)
      $display("FAIL b2b_gap got dec=%h busy=%b want 0000/0",
               b_if.decoder_out, b_if.busy);
    else passed++;
    b_if.addr_in = 8'h2F; b_if.req = 1'b1;
    tick();
    total++;
    if (b_if.decoder_out !== 16'h8000 || b_if.wait_out !== 1'b0)
      $display("FAIL b2b_second got dec=%h wait=%b want 8000/0",
               b_if.decoder_out, b_if.wait_out);
    else passed++;
    b_if.req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [15:0] dec [2];
    logic        wt  [2];
    logic        ht  [2];
    logic        bs  [2];
    logic [15:0] e_dec;
    for (int c = 0; c < 400; c++) begin
      dec[0] = a_if.decoder_out; wt[0] = a_if.wait_out;
      ht[0]  = a_if.hit;         bs[0] = a_if.busy;
      dec[1] = b_if.decoder_out; wt[1] = b_if.wait_out;
      ht[1]  = b_if.hit;         bs[1] = b_if.busy;
      for (int d = 0; d < 2; d++) begin
        e_dec = exp_dec(d);
        total++;
        if (dec[d] !== e_dec || !$onehot0(dec[d]))
          $display("FAIL rnd_dec d%0d c%0d got %h want %h",
                   d, c, dec[d], e_dec);
        else passed++;
        total++;
        if (wt[d] !== (m_sel[d] >= 0 && m_wait[d] > 0))
          $display("FAIL rnd_wait d%0d c%0d got %b want %b",
                   d, c, wt[d], (m_sel[d] >= 0 && m_wait[d] > 0));
        else passed++;
        total++;
        if (ht[d] !== (m_sel[d] >= 0))
          $display("FAIL rnd_hit d%0d c%0d got %b want %b",
                   d, c, ht[d], (m_sel[d] >= 0));
        else passed++;
        total++;
        if (bs[d] !== (m_sel[d] >= 0 || m_miss[d] || m_cool[d] > 0))
          $display("FAIL rnd_busy d%0d c%0d got %b want %b", d, c, bs[d],
                   (m_sel[d] >= 0 || m_miss[d] || m_cool[d] > 0));
        else passed++;
      end
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) a_if.req = ~a_if.req;
      if ($urandom_range(0, 3) == 0) b_if.req = ~b_if.req;
      a_if.enable  = ($urandom_range(0, 9) != 0);
      b_if.enable  = ($urandom_range(0, 9) != 0);
      a_if.addr_in = {($urandom_range(0, 1) != 0) ? 4'h2 : 4'($urandom),
                      4'($urandom)};
      b_if.addr_in = {($urandom_range(0, 1) != 0) ? 4'h2 : 4'($urandom),
                      4'($urandom)};
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b1;
    test_reset();
    test_basic();
    test_reset_mid();
    test_miss();
    test_addr_walk();
    test_enable_drop();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/io_select_decoder.md
Name: io_select_decoder

Overview:
Registered, parametrised successor of the CPLD 4-to-16 combinational port decoder for the I/O board. Matches the upper address bits against a base, decodes the low bits into a one-hot chip-select held for the whole bus request, and asserts wait-states to the Z80 bus. Sits between the bus interface (IORQ/RD/WR qualified into req) and the peripheral selects.

Parameters:
ADDR_W, 8, total address bits presented on addr_in.
SEL_W, 4, low address bits decoded; output width is 2**SEL_W; must be < ADDR_W.
BASE, 4'h2, value the upper ADDR_W-SEL_W address bits must equal for a hit.
WAIT_CYCLES, 2, cycles wait_out is held high per hit; 0 disables wait insertion (range 0..15).
RECOVERY_CYCLES, 1, idle cycles enforced after a request ends before a new one is accepted (range 0..15).

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  synchronous, active-high reset.
addr_in  input  ADDR_W  bus address, sampled only when a request is accepted.
req  input  1  level bus request (qualified IORQ & (RD|WR)), held high for the whole access.
enable  input  1  global decoder enable; low forces all selects off.
decoder_out  output  2**SEL_W  registered one-hot select; all zero when inactive.
wait_out  output  1  registered wait request to bus, active-high.
hit  output  1  high while a matched access owns the decoder (IDLE excluded).
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (sync, active-high): state IDLE, decoder_out=0, wait_out=0, hit=0, busy=0, counters=0. Reset wins over every other input in the same cycle, including mid-access.
- All outputs registered; decode latency 1 cycle from the edge that samples req=1.
- States: IDLE, WAIT, ACTIVE, MISS, RECOVER.
- IDLE: if req & enable & addr_in[ADDR_W-1:SEL_W]==BASE -> latch addr_in[SEL_W-1:0]; next cycle decoder_out = 1<<latched, hit=1; go WAIT with wait_out=1 (or ACTIVE with wait_out=0 if WAIT_CYCLES=0). If req & (!enable | no match) -> MISS, outputs stay 0.
- WAIT: wait_out high for exactly WAIT_CYCLES consecutive cycles, then ACTIVE with wait_out=0. decoder_out held.
- ACTIVE: decoder_out held, wait_out=0, until req=0.
- req falling in WAIT or ACTIVE: next cycle decoder_out=0, wait_out=0, hit=0; go RECOVER (or IDLE if RECOVERY_CYCLES=0).
- enable falling in WAIT or ACTIVE: next cycle decoder_out=0, wait_out=0, hit=0; go MISS if req still high, else RECOVER.
- MISS: outputs zero; stay until req=0, then RECOVER (or IDLE if RECOVERY_CYCLES=0). A req that is still high never retriggers a decode.
- RECOVER: stay RECOVERY_CYCLES cycles ignoring req, then IDLE; a req still high on return to IDLE is a new request only if it was low at some point (edge required: track req_prev, accept in IDLE only when req rose or req_prev was sampled low).
- addr_in changes after acceptance are ignored (latched bits used).
- decoder_out is never multi-hot; at most one bit set in any cycle.

Test Plan:
- Reset mid-access: hit on addr 8'h25, assert reset during WAIT -> next cycle decoder_out=16'h0000, wait_out=0, busy=0.
- Basic hit: WAIT_CYCLES=2, addr_in=8'h25, req high 6 cycles -> decoder_out=16'h0020 one cycle after req sampled, wait_out high exactly 2 cycles, decoder_out clears one cycle after req falls, busy high for 1 RECOVER cycle.
- Miss: addr_in=8'h35, req high 4 cycles -> decoder_out stays 0, wait_out 0, hit 0, busy 1 (MISS) until req low + recovery.
- Address walk: all low nibbles 0..F with BASE 2 -> decoder_out = 16'h0001..16'h8000 respectively, one-hot each, addr_in changed mid-access has no effect.
- Enable drop: hit on 8'h2A, drop enable in ACTIVE with req high -> decoder_out 0 next cycle, no retrigger when enable returns while req still high; new access only after req low and RECOVER.
- Zero-wait/back-to-back: WAIT_CYCLES=0, RECOVERY_CYCLES=0, two requests on 8'h21 then 8'h2F separated by one low cycle -> decoder_out 16'h0002 then 16'h8000, wait_out never asserted.
